enet_rgmii_rx_adapter: RTL and testbench

Parametrised RGMII receive adapter for the enet periph. It sits after the DDR input capture, in the recovered RX clock domain. It converts per-edge RGMII nibbles and control bits into a framed byte stream at 1000, 100 or 10 Mb/s, and adds SOF/last flags, frame length, error/runt/giant status and optional RGMII in-band status decode. It feeds the MAC RX FIFO.

---
 rtl/enet_rgmii_rx_adapter.sv | 190 +++++++++++++++++++
 tb/tb_enet_rgmii_rx_adapter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enet_rgmii_rx_adapter.sv
// RGMII receive adapter: turns per-edge nibbles and RX_CTL into a framed byte stream with status.
// Define ENET_RX_IBS_EN to decode RGMII in-band link status and take the speed from it.
module enet_rgmii_rx_adapter #(
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned MIN_FRAME_LEN = 64,
  parameter int unsigned MAX_FRAME_LEN = 1522
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       rxd_r,
  input  logic [3:0]       rxd_f,
  input  logic             ctl_r,
  input  logic             ctl_f,
  input  logic [1:0]       speed_sel,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sof,
  output logic             out_last,
  output logic             out_err,
  output logic             out_runt,
  output logic             out_giant,
  output logic [CNT_W-1:0] out_len,
  output logic             link_up,
  output logic [1:0]       link_speed,
  output logic             link_duplex
);

  logic [3:0]       s_rxd_r, s_rxd_f;
  logic             s_dv, s_er;
  logic [1:0]       s_speed;

  logic             dv_prev_q;
  logic [1:0]       speed_q;
  logic             phase_q;
  logic [3:0]       nib_q;
  logic             first_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;
  logic             hold_valid_q;
  logic [7:0]       hold_data_q;
  logic             hold_sof_q;
  logic             hold_odd_q;

  logic [1:0]       spd_src;
  logic             rise, done, odd_end, phase_d, emit_last, err_d;
  logic [1:0]       spd_eff;
  logic [7:0]       byte_val;
  logic [3:0]       nib_d;
  logic [CNT_W-1:0] cnt_base, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_rxd_r <= '0;
      s_rxd_f <= '0;
      s_dv    <= 1'b0;
      s_er    <= 1'b0;
      s_speed <= '0;
    end else begin
      s_rxd_r <= rxd_r;
      s_rxd_f <= rxd_f;
      s_dv    <= ctl_r;
      s_er    <= ctl_r ^ ctl_f;
      s_speed <= speed_sel;
    end
  end

`ifdef ENET_RX_IBS_EN
  logic [3:0] ibs_prev_q;
  logic       ibs_vld_q;
  logic       link_up_q;
  logic [1:0] link_speed_q;
  logic       link_duplex_q;
  logic       unused_speed;

  assign unused_speed = ^s_speed;

  // Idle samples with er=1 are skipped without breaking the run of identical samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      ibs_prev_q    <= '0;
      ibs_vld_q     <= 1'b0;
      link_up_q     <= 1'b0;
      link_speed_q  <= '0;
      link_duplex_q <= 1'b0;
    end else if (s_dv) begin
      ibs_vld_q <= 1'b0;
    end else if (!s_er) begin
      ibs_prev_q <= s_rxd_r;
      ibs_vld_q  <= 1'b1;
      if (ibs_vld_q && (ibs_prev_q == s_rxd_r)) begin
        link_up_q     <= s_rxd_r[0];
        link_speed_q  <= s_rxd_r[2:1];
        link_duplex_q <= s_rxd_r[3];
      end
    end
  end

  assign link_up     = link_up_q;
  assign link_speed  = link_speed_q;
  assign link_duplex = link_duplex_q;
  assign spd_src     = link_speed_q;
`else
  assign link_up     = 1'b0;
  assign link_speed  = 2'b00;
  assign link_duplex = 1'b0;
  assign spd_src     = s_speed;
`endif

  always_comb begin
    rise     = s_dv & ~dv_prev_q;
    spd_eff  = rise ? spd_src : speed_q;
    done     = 1'b0;
    odd_end  = 1'b0;
    byte_val = '0;
    phase_d  = phase_q;
    nib_d    = nib_q;
    if (s_dv) begin
      if (spd_eff[1]) begin
        done     = 1'b1;
        byte_val = {s_rxd_f, s_rxd_r};
      end else if (rise || !phase_q) begin
        phase_d = 1'b1;
        nib_d   = s_rxd_r;
      end else begin
        done     = 1'b1;
        byte_val = {s_rxd_r, nib_q};
        phase_d  = 1'b0;
      end
    end else if (phase_q) begin
      // dv fell with a lone low nibble pending: flush it as an errored last byte.
      done     = 1'b1;
      odd_end  = 1'b1;
      byte_val = {4'h0, nib_q};
      phase_d  = 1'b0;
    end
    emit_last = hold_valid_q & (hold_odd_q | ~s_dv);
    // The next frame's first byte may be counted in the same cycle the old count is issued.
    cnt_base  = emit_last ? '0 : cnt_q;
    cnt_d     = (done && !(&cnt_base)) ? cnt_base + CNT_W'(1) : cnt_base;
    err_d     = (emit_last ? 1'b0 : err_q) | (s_dv & s_er);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dv_prev_q    <= 1'b0;
      speed_q      <= '0;
      phase_q      <= 1'b0;
      nib_q        <= '0;
      first_q      <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_sof_q   <= 1'b0;
      hold_odd_q   <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_sof      <= 1'b0;
      out_last     <= 1'b0;
      out_err      <= 1'b0;
      out_runt     <= 1'b0;
      out_giant    <= 1'b0;
      out_len      <= '0;
    end else begin
      dv_prev_q <= s_dv;
      if (rise) speed_q <= spd_src;
      phase_q <= phase_d;
      nib_q   <= nib_d;
      if (done)      first_q <= 1'b0;
      else if (rise) first_q <= 1'b1;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= done;
      if (done) begin
        hold_data_q <= byte_val;
        hold_sof_q  <= rise | first_q;
        hold_odd_q  <= odd_end;
      end
      out_valid <= hold_valid_q;
      out_data  <= hold_valid_q ? hold_data_q : '0;
      out_sof   <= hold_valid_q & hold_sof_q;
      out_last  <= emit_last;
      out_err   <= emit_last & (err_q | hold_odd_q);
      out_runt  <= emit_last & (cnt_q < CNT_W'(MIN_FRAME_LEN));
      out_giant <= emit_last & (cnt_q > CNT_W'(MAX_FRAME_LEN));
      out_len   <= emit_last ? cnt_q : '0;
    end
  end

endmodule

// File: tb/tb_enet_rgmii_rx_adapter.sv
// Directed bench for enet_rgmii_rx_adapter: 1000/100/10 framing, status flags, reset and in-band status.
// Define ENET_RX_IBS_EN to exercise the in-band status build.
module tb_enet_rgmii_rx_adapter;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       rxd_r, rxd_f;
  logic             ctl_r, ctl_f;
  logic [1:0]       speed_sel;
  logic             out_valid, out_sof, out_last, out_err, out_runt, out_giant;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] out_len;
  logic             link_up, link_duplex;
  logic [1:0]       link_speed;

  enet_rgmii_rx_adapter #(
    .CNT_W        (CNT_W),
    .MIN_FRAME_LEN(64),
    .MAX_FRAME_LEN(1522)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd_r      (rxd_r),
    .rxd_f      (rxd_f),
    .ctl_r      (ctl_r),
    .ctl_f      (ctl_f),
    .speed_sel  (speed_sel),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_last   (out_last),
    .out_err    (out_err),
    .out_runt   (out_runt),
    .out_giant  (out_giant),
    .out_len    (out_len),
    .link_up    (link_up),
    .link_speed (link_speed),
    .link_duplex(link_duplex)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  logic [3:0] idle_nib = 4'h0;

  logic [7:0] cap_data[$];
  bit         cap_sof[$], cap_last[$], cap_err[$], cap_runt[$], cap_giant[$];
  int         cap_len[$], cap_cyc[$];

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      cap_data.push_back(out_data);
      cap_sof.push_back(out_sof);
      cap_last.push_back(out_last);
      cap_err.push_back(out_err);
      cap_runt.push_back(out_runt);
      cap_giant.push_back(out_giant);
      cap_len.push_back(int'(out_len));
      cap_cyc.push_back(cyc);
    end
  end

  task automatic clear_cap();
    cap_data.delete(); cap_sof.delete(); cap_last.delete(); cap_err.delete();
    cap_runt.delete(); cap_giant.delete(); cap_len.delete(); cap_cyc.delete();
  endtask

  task automatic idle(input int n);
    rxd_r = idle_nib; rxd_f = 4'h0; ctl_r = 1'b0; ctl_f = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gig_byte(input logic [7:0] b, input logic er);
    rxd_r = b[3:0]; rxd_f = b[7:4]; ctl_r = 1'b1; ctl_f = ~er;
    @(posedge clk);
    #1;
  endtask

  task automatic nib(input logic [3:0] n);
    rxd_r = n; rxd_f = 4'h0; ctl_r = 1'b1; ctl_f = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle nibble advertises the same speed so the in-band build assembles identically.
  task automatic set_speed(input logic [1:0] s);
    speed_sel = s;
    idle_nib  = {1'b1, s, 1'b1};
    idle(4);
  endtask

  task automatic test_reset();
    rst = 1'b1; speed_sel = 2'b10; idle_nib = 4'h0;
    rxd_r = 4'hF; rxd_f = 4'hF; ctl_r = 1'b1; ctl_f = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (out_len !== '0) $display("FAIL reset_len: got %0d want 0", out_len); else n_pass++;
    n_chk++;
    if ({link_up, link_speed, link_duplex} !== 4'b0)
      $display("FAIL reset_link: got %b want 0000", {link_up, link_speed, link_duplex});
    else n_pass++;
    ctl_r = 1'b0; ctl_f = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_gig_64();
    int start, bad;
    set_speed(2'b10);
    clear_cap();
    start = cyc;
    for (int i = 0; i < 64; i++) gig_byte(8'(i), 1'b0);
    idle(6);
    n_chk++; if (cap_data.size() != 64) $display("FAIL g64_count: got %0d want 64", cap_data.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (cap_data[i] !== 8'(i) || cap_sof[i] !== (i == 0) || cap_last[i] !== (i == 63)) bad++;
      if (i > 0 && cap_cyc[i] != cap_cyc[i-1] + 1) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL g64_bytes: got %0d bad want 0", bad); else n_pass++;
    n_chk++; if (cap_cyc[0] != start + 3) $display("FAIL g64_latency: got %0d want %0d", cap_cyc[0], start + 3); else n_pass++;
    n_chk++; if (cap_len[63] != 64) $display("FAIL g64_len: got %0d want 64", cap_len[63]); else n_pass++;
    n_chk++;
    if ({cap_err[63], cap_runt[63], cap_giant[63]} !== 3'b000)
      $display("FAIL g64_flags: got %b want 000", {cap_err[63], cap_runt[63], cap_giant[63]});
    else n_pass++;
  endtask

  task automatic test_100_preamble();
    logic [7:0] exp [9] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12};
    int bad;
    set_speed(2'b01);
    clear_cap();
    for (int i = 0; i < 15; i++) nib(4'h5);
    nib(4'hD); nib(4'h2); nib(4'h1);
    idle(6);
    n_chk++; if (cap_data.size() != 9) $display("FAIL m100_count: got %0d want 9", cap_data.size()); else n_pass++;
    bad = 0;
    for (int i = 0; i < 9; i++) begin
      if (cap_data[i] !== exp[i] || cap_last[i] !== (i == 8)) bad++;
      if (i > 0 && cap_cyc[i] != cap_cyc[i-1] + 2) bad++;
    end
    n_chk++; if (bad != 0) $display("FAIL m100_bytes: got %0d bad want 0", bad); else n_pass++;
    n_chk++;
    if ({cap_len[8] == 9, cap_err[8], cap_runt[8], cap_sof[0]} !== 4'b1011)
      $display("FAIL m100_status: got len %0d err %b runt %b sof %b want 9/0/1/1",
               cap_len[8], cap_err[8], cap_runt[8], cap_sof[0]);
    else n_pass++;
  endtask

  task automatic test_10_odd();
    set_speed(2'b00);
    clear_cap();
    nib(4'h3); nib(4'h4); nib(4'hA);
    idle(8);
    n_chk++; if (cap_data.size() != 2) $display("FAIL m10_count: got %0d want 2", cap_data.size()); else n_pass++;
    n_chk++;
    if ({cap_data[0], cap_last[0]} !== {8'h43, 1'b0})
      $display("FAIL m10_first: got %h last %b want 43 last 0", cap_data[0], cap_last[0]);
    else n_pass++;
    n_chk++;
    if ({cap_data[1], cap_last[1], cap_err[1]} !== {8'h0A, 1'b1, 1'b1})
      $display("FAIL m10_odd: got %h last %b err %b want 0a 1 1", cap_data[1], cap_last[1], cap_err[1]);
    else n_pass++;
    n_chk++; if (cap_len[1] != 2) $display("FAIL m10_len: got %0d want 2", cap_len[1]); else n_pass++;
  endtask

  task automatic test_err_runt();
    set_speed(2'b10);
    clear_cap();
    for (int i = 0; i < 60; i++) gig_byte(8'(i + 100), i == 10);
    idle(6);
    n_chk++; if (cap_data.size() != 60) $display("FAIL er_count: got %0d want 60", cap_data.size()); else n_pass++;
    n_chk++;
    if ({cap_last[59], cap_err[59], cap_runt[59], cap_giant[59]} !== 4'b1110)
      $display("FAIL er_flags: got %b want 1110", {cap_last[59], cap_err[59], cap_runt[59], cap_giant[59]});
    else n_pass++;
    n_chk++; if (cap_len[59] != 60) $display("FAIL er_len: got %0d want 60", cap_len[59]); else n_pass++;
  endtask

  task automatic test_giant_reset();
    int lasts;
    set_speed(2'b10);
    clear_cap();
    for (int i = 0; i < 1600; i++) gig_byte(8'(i), 1'b0);
    idle(6);
    n_chk++; if (cap_data.size() != 1600) $display("FAIL gi_count: got %0d want 1600", cap_data.size()); else n_pass++;
    n_chk++;
    if ({cap_giant[1599], cap_runt[1599], cap_err[1599]} !== 3'b100)
      $display("FAIL gi_flags: got %b want 100", {cap_giant[1599], cap_runt[1599], cap_err[1599]});
    else n_pass++;
    n_chk++; if (cap_len[1599] != 1600) $display("FAIL gi_len: got %0d want 1600", cap_len[1599]); else n_pass++;
    clear_cap();
    for (int i = 0; i < 20; i++) gig_byte(8'hEE, 1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    lasts = 0;
    foreach (cap_last[i]) if (cap_last[i]) lasts++;
    n_chk++; if (lasts != 0) $display("FAIL rst_nolast: got %0d lasts want 0", lasts); else n_pass++;
    clear_cap();
    for (int i = 0; i < 70; i++) gig_byte(8'(i + 7), 1'b0);
    idle(6);
    n_chk++; if (cap_data.size() != 70) $display("FAIL rst_next_count: got %0d want 70", cap_data.size()); else n_pass++;
    n_chk++;
    if ({cap_len[69] == 70, cap_last[69], cap_sof[0], cap_runt[69], cap_err[69]} !== 5'b11100)
      $display("FAIL rst_next_status: got len %0d last %b sof %b runt %b err %b want 70/1/1/0/0",
               cap_len[69], cap_last[69], cap_sof[0], cap_runt[69], cap_err[69]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    set_speed(2'b10);
    clear_cap();
    gig_byte(8'hA0, 1'b0); gig_byte(8'hA1, 1'b0); gig_byte(8'hA2, 1'b0);
    idle(1);
    gig_byte(8'hB0, 1'b0); gig_byte(8'hB1, 1'b0);
    idle(6);
    n_chk++; if (cap_data.size() != 5) $display("FAIL b2b_count: got %0d want 5", cap_data.size()); else n_pass++;
    n_chk++;
    if ({cap_sof[0], cap_last[2], cap_sof[3], cap_last[4], cap_last[3]} !== 5'b11110)
      $display("FAIL b2b_framing: got %b want 11110", {cap_sof[0], cap_last[2], cap_sof[3], cap_last[4], cap_last[3]});
    else n_pass++;
    n_chk++;
    if (cap_len[2] != 3 || cap_len[4] != 2 || cap_data[3] !== 8'hB0)
      $display("FAIL b2b_len: got %0d,%0d data %h want 3,2 data b0", cap_len[2], cap_len[4], cap_data[3]);
    else n_pass++;
  endtask

  task automatic test_inband();
    speed_sel = 2'b00;
    idle_nib  = 4'b1101;
    idle(4);
`ifdef ENET_RX_IBS_EN
    n_chk++;
    if ({link_up, link_speed, link_duplex} !== 4'b1101)
      $display("FAIL ibs_link: got %b want 1101", {link_up, link_speed, link_duplex});
    else n_pass++;
    clear_cap();
    gig_byte(8'h11, 1'b0); gig_byte(8'h22, 1'b0); gig_byte(8'h33, 1'b0); gig_byte(8'h44, 1'b0);
    idle(6);
    n_chk++;
    if (cap_data.size() != 4 || cap_data[3] !== 8'h44 || cap_len[3] != 4)
      $display("FAIL ibs_gig: got %0d bytes last %h len %0d want 4 bytes 44 len 4",
               cap_data.size(), cap_data[3], cap_len[3]);
    else n_pass++;
`else
    n_chk++;
    if ({link_up, link_speed, link_duplex} !== 4'b0000)
      $display("FAIL ibs_tied: got %b want 0000", {link_up, link_speed, link_duplex});
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_gig_64();
    test_100_preamble();
    test_10_odd();
    test_err_runt();
    test_giant_reset();
    test_back_to_back();
    test_inband();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
